// File: rtl/msg_arbiter_rr.sv
// msg_arbiter_rr: round-robin scheduler sharing one message channel among NREQ requesters.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - per-requester offer
//   req_code   - per-requester code, requester i at [i*CODE_W +: CODE_W]
//   req_ready  - one-hot (or zero) acceptance of the winning requester this cycle
//   msg_valid  - shared output channel holds a message
//   msg_code   - registered code of the granted requester
//   msg_src    - index of the granted requester
//   msg_ready  - consumer accepts the message when high with msg_valid
//   msg_cnt    - count of accepted output messages, wraps modulo 2^CNT_W
module msg_arbiter_rr #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CODE_W-1:0] req_code,
    output logic [NREQ-1:0]        req_ready,
    output logic                   msg_valid,
    output logic [CODE_W-1:0]      msg_code,
    output logic [SRC_W-1:0]       msg_src,
    input  logic                   msg_ready,
    output logic [CNT_W-1:0]       msg_cnt
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CODE_W-1:0]   code_arr [NREQ];
    logic                found;
    logic [SRC_W-1:0]    winner;
    logic [SRC_W-1:0]    idx;
    logic                load_win;
    logic                out_hs;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            code_arr[i] = req_code[i*CODE_W +: CODE_W];
        end
    end

    // Priority search starting at ptr, ascending with wrap; first set bit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = SRC_W'((32'(ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign load_win = (state_q == StIdle) || msg_ready;
    assign out_hs   = (state_q == StSend) && msg_ready;

    // Gated by rst_n so nothing is accepted during a reset cycle.
    always_comb begin
        req_ready = '0;
        if (rst_n && load_win && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load_win) begin
            if (found) begin
                state_d = StSend;
                code_d  = code_arr[winner];
                src_d   = winner;
                ptr_d   = (winner == SRC_W'(NREQ - 1)) ? '0 : winner + SRC_W'(1);
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msg_valid = (state_q == StSend);
    assign msg_code  = code_q;
    assign msg_src   = src_q;
    assign msg_cnt   = cnt_q;

endmodule

// File: tb/tb_msg_arbiter_rr.sv
// Self-checking bench for msg_arbiter_rr: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural model of the scheduling rules.
module tb_msg_arbiter_rr;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SRC_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*CODE_W-1:0] req_code = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   msg_valid;
    logic [CODE_W-1:0]      msg_code;
    logic [SRC_W-1:0]       msg_src;
    logic                   msg_ready = 1'b0;
    logic [CNT_W-1:0]       msg_cnt;

    always #5 clk = ~clk;

    msg_arbiter_rr #(
        .NREQ   (NREQ),
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W),
        .SRC_W  (SRC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .msg_valid (msg_valid),
        .msg_code  (msg_code),
        .msg_src   (msg_src),
        .msg_ready (msg_ready),
        .msg_cnt   (msg_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_valid = 0;
    int m_code  = 0;
    int m_src   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [NREQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round-robin pick: first valid requester at or after p, wrapping.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endfunction

    // One clock cycle: drive, check against the model mid-cycle, advance model at the edge.
    task automatic step(input logic rst, input logic [NREQ-1:0] v,
                        input logic [15:0] codes, input logic rdy);
        int w;
        logic [NREQ-1:0] exp_ready;
        #1;
        rst_n     = rst;
        req_valid = v;
        req_code  = codes;
        msg_ready = rdy;
        w = pick(v, m_ptr);
        exp_ready = '0;
        if (rst && (m_valid == 0 || rdy) && w >= 0) exp_ready[w] = 1'b1;
        @(negedge clk);
        obs_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("msg_valid", 32'(msg_valid), 32'(m_valid));
        if (m_valid != 0) begin
            check("msg_code", 32'(msg_code), 32'(m_code));
            check("msg_src", 32'(msg_src), 32'(m_src));
        end
        check("msg_cnt", 32'(msg_cnt), 32'(m_cnt));
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_code = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid != 0 && rdy) m_cnt = (m_cnt + 1) % 256;
            if (m_valid == 0 || rdy) begin
                if (w >= 0) begin
                    m_valid = 1;
                    m_code  = int'(codes[w*CODE_W +: CODE_W]);
                    m_src   = w;
                    m_ptr   = (w + 1) % NREQ;
                end else begin
                    m_valid = 0;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] c;
        c = pack(5, 4, 3, 2);

        // Reset release with no requests
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        repeat (3) step(1'b1, 4'b0000, 16'h0, 1'b1);
        step(1'b1, 4'b0010, pack(0, 5, 0, 0), 1'b1);
        check("t1_ready", 32'(obs_ready), 32'h2);
        #1;
        check("t1_valid", 32'(msg_valid), 32'h1);
        check("t1_code", 32'(msg_code), 32'h5);
        check("t1_src", 32'(msg_src), 32'h1);

        // All requesters valid, full throughput
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, c, 1'b1);
            #1;
            check("rr_src", 32'(msg_src), 32'(i % 4));
            check("rr_code", 32'(msg_code), 32'(5 - (i % 4)));
            check("rr_cnt", 32'(msg_cnt), 32'(i));
        end

        // Backpressure with code 3 loaded
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        step(1'b1, 4'b0001, pack(3, 0, 0, 0), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, c, 1'b0);
            check("bp_ready", 32'(obs_ready), 32'h0);
            #1;
            check("bp_code", 32'(msg_code), 32'h3);
            check("bp_src", 32'(msg_src), 32'h0);
            check("bp_cnt", 32'(msg_cnt), 32'h0);
        end
        step(1'b1, 4'b0000, 16'h0, 1'b1);
        #1;
        check("bp_release_cnt", 32'(msg_cnt), 32'h1);

        // Fairness after skip: get ptr to 2 first
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        step(1'b1, 4'b0010, c, 1'b1);
        step(1'b1, 4'b0011, c, 1'b1);
        check("fair_first", 32'(obs_ready), 32'h1);
        step(1'b1, 4'b0011, c, 1'b1);
        check("fair_second", 32'(obs_ready), 32'h2);
        step(1'b1, 4'b1111, c, 1'b1);
        check("fair_ptr", 32'(obs_ready), 32'h4);

        // Counter wrap
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        step(1'b1, 4'b1111, c, 1'b1);
        repeat (255) step(1'b1, 4'b1111, c, 1'b1);
        #1;
        check("wrap_255", 32'(msg_cnt), 32'hff);
        step(1'b1, 4'b1111, c, 1'b1);
        #1;
        check("wrap_0", 32'(msg_cnt), 32'h0);

        // Reset mid-SEND with msg_ready high
        step(1'b0, 4'b0000, 16'h0, 1'b0);
        step(1'b1, 4'b1111, c, 1'b1);
        step(1'b1, 4'b1111, c, 1'b1);
        step(1'b0, 4'b1111, c, 1'b1);
        #1;
        check("rst_valid", 32'(msg_valid), 32'h0);
        check("rst_cnt", 32'(msg_cnt), 32'h0);
        step(1'b1, 4'b1111, c, 1'b1);
        check("rst_ptr", 32'(obs_ready), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 49) != 0), 4'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
